// File: rtl/vga_mono_filter_pipe.sv
// Three-stage VGA colour/monochrome filter: RGB -> luma, then green/amber/white tint or colour pass-through.
// Optional scanline dimming is compiled in with `define MONO_SCANLINE_EN.
module vga_mono_filter_pipe #(
  parameter int CW       = 6,
  parameter int SYNC_POL = 0,
  parameter int KR       = 54,
  parameter int KG       = 183,
  parameter int KB       = 18
) (
  input  logic          clk_vga,
  input  logic          reset_n,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [1:0]    mode_in,
  input  logic          scan_en,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [1:0]    mode_act
);

  localparam int   PW = CW + 8;
  localparam int   SW = CW + 10;
  localparam logic SP = (SYNC_POL != 0);

  function automatic logic [CW-1:0] luma_round(input logic [PW-1:0] pr, input logic [PW-1:0] pg,
                                               input logic [PW-1:0] pb);
    return CW'((SW'(pr) + SW'(pg) + SW'(pb) + SW'(128)) >> 8);
  endfunction

  logic          vs_prev;
  logic          vs_edge;
  logic [1:0]    mode_px;
  logic [PW-1:0] pr_in, pg_in, pb_in;

  assign vs_edge = (vsync_in == SP) && (vs_prev != SP);
  // The pixel arriving with the vsync edge already uses the newly latched mode.
  assign mode_px = vs_edge ? mode_in : mode_act;
  assign pr_in   = PW'(r_in) * PW'(KR);
  assign pg_in   = PW'(g_in) * PW'(KG);
  assign pb_in   = PW'(b_in) * PW'(KB);

`ifdef MONO_SCANLINE_EN
  function automatic logic [CW-1:0] dim_half(input logic [CW-1:0] v, input logic en);
    return en ? (v >> 1) : v;
  endfunction

  logic hs_prev;
  logic line_par;
  logic par_px;
  logic hs_edge;
  logic dim_p0, dim_p1;

  assign hs_edge = (hsync_in == SP) && (hs_prev != SP);

  always_comb begin
    par_px = line_par;
    if (vs_edge)
      par_px = 1'b0;
    else if (hs_edge)
      par_px = ~line_par;
  end

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev  <= ~SP;
      line_par <= 1'b0;
      dim_p0   <= 1'b0;
      dim_p1   <= 1'b0;
    end else begin
      hs_prev  <= hsync_in;
      line_par <= par_px;
      dim_p0   <= scan_en & par_px;
      dim_p1   <= dim_p0;
    end
  end
`else
  logic unused_scan;
  assign unused_scan = scan_en;
`endif

  logic [CW-1:0] r_p0, g_p0, b_p0;
  logic [PW-1:0] pr_p0, pg_p0, pb_p0;
  logic          hs_p0, vs_p0;
  logic [1:0]    mode_p0;

  // Stage 1: input capture and coefficient products
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev  <= ~SP;
      mode_act <= 2'b00;
      r_p0     <= '0;
      g_p0     <= '0;
      b_p0     <= '0;
      pr_p0    <= '0;
      pg_p0    <= '0;
      pb_p0    <= '0;
      hs_p0    <= ~SP;
      vs_p0    <= ~SP;
      mode_p0  <= 2'b00;
    end else begin
      vs_prev  <= vsync_in;
      mode_act <= mode_px;
      r_p0     <= r_in;
      g_p0     <= g_in;
      b_p0     <= b_in;
      pr_p0    <= pr_in;
      pg_p0    <= pg_in;
      pb_p0    <= pb_in;
      hs_p0    <= hsync_in;
      vs_p0    <= vsync_in;
      mode_p0  <= mode_px;
    end
  end

  logic [CW-1:0] r_p1, g_p1, b_p1, y_p1;
  logic          hs_p1, vs_p1;
  logic [1:0]    mode_p1;

  // Stage 2: rounded luma
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      r_p1    <= '0;
      g_p1    <= '0;
      b_p1    <= '0;
      y_p1    <= '0;
      hs_p1   <= ~SP;
      vs_p1   <= ~SP;
      mode_p1 <= 2'b00;
    end else begin
      r_p1    <= r_p0;
      g_p1    <= g_p0;
      b_p1    <= b_p0;
      y_p1    <= luma_round(pr_p0, pg_p0, pb_p0);
      hs_p1   <= hs_p0;
      vs_p1   <= vs_p0;
      mode_p1 <= mode_p0;
    end
  end

  logic [CW-1:0] r_nx, g_nx, b_nx;

  always_comb begin
    r_nx = r_p1;
    g_nx = g_p1;
    b_nx = b_p1;
    case (mode_p1)
      2'b01: begin
        r_nx = '0;
        g_nx = y_p1;
        b_nx = '0;
      end
      2'b10: begin
        r_nx = y_p1;
        g_nx = y_p1 >> 1;
        b_nx = '0;
      end
      2'b11: begin
        r_nx = y_p1;
        g_nx = y_p1;
        b_nx = y_p1;
      end
      default: ;
    endcase
`ifdef MONO_SCANLINE_EN
    r_nx = dim_half(r_nx, dim_p1);
    g_nx = dim_half(g_nx, dim_p1);
    b_nx = dim_half(b_nx, dim_p1);
`endif
  end

  // Stage 3: tint select and output registers
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      hsync_out <= ~SP;
      vsync_out <= ~SP;
    end else begin
      r_out     <= r_nx;
      g_out     <= g_nx;
      b_out     <= b_nx;
      hsync_out <= hs_p1;
      vsync_out <= vs_p1;
    end
  end

endmodule

// File: tb/tb_vga_mono_filter_pipe.sv
// Randomised self-checking bench for vga_mono_filter_pipe against a pixel-level reference model.
module tb_vga_mono_filter_pipe;

  localparam logic SP = 1'b0;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic       hs;
    logic       vs;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] r_in = '0, g_in = '0, b_in = '0;
  logic       hsync_in = ~SP, vsync_in = ~SP;
  logic [1:0] mode_in = 2'b00;
  logic       scan_en = 1'b0;
  logic [5:0] r_out, g_out, b_out;
  logic       hsync_out, vsync_out;
  logic [1:0] mode_act;

  int total = 0;
  int bad = 0;

  exp_t       q[$];
  logic       m_vsp, m_hsp, m_par;
  logic [1:0] m_mode;

  vga_mono_filter_pipe dut (
    .clk_vga(clk), .reset_n(reset_n),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mode_in(mode_in), .scan_en(scan_en),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .mode_act(mode_act)
  );

  always #5 clk = ~clk;

  // Model restart: two pipeline slots still hold reset values after release.
  task automatic model_reset();
    exp_t z;
    z = '0;
    z.hs = ~SP;
    z.vs = ~SP;
    q.delete();
    q.push_back(z);
    q.push_back(z);
    m_vsp = ~SP;
    m_hsp = ~SP;
    m_par = 1'b0;
    m_mode = 2'b00;
  endtask

  // Drive one pixel, clock it in, and return what should now be at the outputs.
  task automatic px(input int r, input int g, input int b, input logic hs, input logic vs,
                    input logic [1:0] md, input logic sc, output exp_t e);
    exp_t n;
    int y;
    logic ve, he;
    r_in = r[5:0]; g_in = g[5:0]; b_in = b[5:0];
    hsync_in = hs; vsync_in = vs; mode_in = md; scan_en = sc;
    ve = (vs == SP) && (m_vsp != SP);
    he = (hs == SP) && (m_hsp != SP);
    m_vsp = vs;
    m_hsp = hs;
    if (ve) m_mode = md;
    if (ve) m_par = 1'b0;
    else if (he) m_par = ~m_par;
    y = (r * 54 + g * 183 + b * 18 + 128) / 256;
    n.hs = hs;
    n.vs = vs;
    case (m_mode)
      2'b00: begin n.r = r[5:0]; n.g = g[5:0]; n.b = b[5:0]; end
      2'b01: begin n.r = 0; n.g = y[5:0]; n.b = 0; end
      2'b10: begin n.r = y[5:0]; n.g = 6'(y / 2); n.b = 0; end
      default: begin n.r = y[5:0]; n.g = y[5:0]; n.b = y[5:0]; end
    endcase
`ifdef MONO_SCANLINE_EN
    if (sc && m_par) begin
      n.r = n.r / 2; n.g = n.g / 2; n.b = n.b / 2;
    end
`endif
    q.push_back(n);
    @(posedge clk);
    #1;
    e = q.pop_front();
  endtask

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({r_out, g_out, b_out, hsync_out, vsync_out, mode_act} !== {18'd0, ~SP, ~SP, 2'b00}) begin
      bad++;
      $display("FAIL reset_init: got %h exp %h", {r_out, g_out, b_out, hsync_out, vsync_out, mode_act},
               {18'd0, ~SP, ~SP, 2'b00});
    end
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      px(63, 63, 63, ~SP, (i == 0) ? SP : ~SP, 2'b11, 1'b0, e);
      total++;
      if ({r_out, g_out, b_out, hsync_out, vsync_out} !== e) begin
        bad++;
        $display("FAIL reset_pre: got %h exp %h", {r_out, g_out, b_out, hsync_out, vsync_out}, e);
      end
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({r_out, g_out, b_out, hsync_out, vsync_out, mode_act} !== {18'd0, ~SP, ~SP, 2'b00}) begin
      bad++;
      $display("FAIL reset_async: got %h exp %h", {r_out, g_out, b_out, hsync_out, vsync_out, mode_act},
               {18'd0, ~SP, ~SP, 2'b00});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      px(10, 20, 30, (i == 1) ? SP : ~SP, ~SP, 2'b11, 1'b0, e);
      total++;
      if ({r_out, g_out, b_out, hsync_out, vsync_out} !== e || mode_act !== m_mode) begin
        bad++;
        $display("FAIL reset_release: got %h/%0d exp %h/%0d", {r_out, g_out, b_out, hsync_out, vsync_out},
                 mode_act, e, m_mode);
      end
    end
  endtask

  task automatic test_white();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      px(63, 63, 63, (i % 4 == 2) ? SP : ~SP, (i < 2) ? SP : ~SP, 2'b11, 1'b0, e);
      total++;
      if ({r_out, g_out, b_out, hsync_out, vsync_out} !== e) begin
        bad++;
        $display("FAIL white: got %h exp %h", {r_out, g_out, b_out, hsync_out, vsync_out}, e);
      end
    end
  endtask

  task automatic test_green_amber();
    exp_t e;
    int pat[4][3] = '{'{63, 0, 0}, '{0, 63, 0}, '{0, 0, 63}, '{10, 20, 30}};
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) begin
        px(pat[i % 4][0], pat[i % 4][1], pat[i % 4][2], ~SP, (i == 0) ? SP : ~SP, 2'(f), 1'b0, e);
        total++;
        if ({r_out, g_out, b_out, hsync_out, vsync_out} !== e) begin
          bad++;
          $display("FAIL tint_mode%0d: got %h exp %h", f, {r_out, g_out, b_out, hsync_out, vsync_out}, e);
        end
      end
    end
  endtask

  task automatic test_mode_frame();
    exp_t e;
    for (int i = 0; i < 14; i++) begin
      px(10, 20, 30, ~SP, (i == 0 || i == 8) ? SP : ~SP, (i == 0) ? 2'b00 : 2'b11, 1'b0, e);
      total++;
      if ({r_out, g_out, b_out, hsync_out, vsync_out} !== e || mode_act !== m_mode) begin
        bad++;
        $display("FAIL mode_frame: got %h/%0d exp %h/%0d", {r_out, g_out, b_out, hsync_out, vsync_out},
                 mode_act, e, m_mode);
      end
    end
  endtask

  task automatic test_scanline();
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      px(63, 63, 63, (i % 8 == 0) ? SP : ~SP, (i % 32 < 2) ? SP : ~SP, 2'b11, 1'b1, e);
      total++;
      if ({r_out, g_out, b_out, hsync_out, vsync_out} !== e) begin
        bad++;
        $display("FAIL scanline: got %h exp %h", {r_out, g_out, b_out, hsync_out, vsync_out}, e);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 400; i++) begin
      px($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
         (i % 10 == 0) ? SP : ~SP, (i % 60 < 2) ? SP : ~SP,
         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), e);
      total++;
      if ({r_out, g_out, b_out, hsync_out, vsync_out} !== e || mode_act !== m_mode) begin
        bad++;
        $display("FAIL random: got %h/%0d exp %h/%0d", {r_out, g_out, b_out, hsync_out, vsync_out},
                 mode_act, e, m_mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_white();
    test_green_amber();
    test_mode_frame();
    test_scanline();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
